// File: rtl/apb_uart_pkg.sv
// Shared constants for the APB UART receive register block.
// Address map, STATUS bit positions and reset values.
package apb_uart_pkg;

    localparam int A_STATUS = 0;
    localparam int A_BP_LO  = 2;
    localparam int A_BP_HI  = 3;
    localparam int A_DSIZE  = 4;
    localparam int A_RXDATA = 6;

    localparam int ST_READY   = 0;
    localparam int ST_OVERRUN = 1;
    localparam int ST_FRAMING = 2;

    localparam logic [13:0] BP_RST = 14'd10;
    localparam logic [3:0]  DS_RST = 4'd8;

    localparam int FIFO_DEPTH = 4;

    function automatic logic ds_legal(input logic [31:0] v);
        return (v == 32'd5) || (v == 32'd7) || (v == 32'd8);
    endfunction

endpackage

// File: rtl/apb_uart_rx_regs_if.sv
// APB subordinate bus bundle (no PREADY, fixed two-cycle transfers).
interface apb_uart_rx_regs_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              psaterr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, psaterr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, psaterr
    );
endinterface

// File: rtl/apb_uart_rx_regs_rx_fifo.sv
// Small receive FIFO with wrap-around pointers and an occupancy count.
// A push while full is accepted only when a pop happens on the same edge.
module rx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= nxt(wr_ptr);
            end
            if (do_pop)
                rd_ptr <= nxt(rd_ptr);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/apb_uart_rx_regs.sv
// APB register block for a UART receiver: config, status and receive data.
// Define APB_UART_RX_FIFO_EN for a 4-entry FIFO instead of one holding register.
module apb_uart_rx_regs
    import apb_uart_pkg::*;
#(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    apb_uart_rx_regs_if.slave apb,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    input  logic        rx_framing_err,
    output logic [13:0] bit_period,
    output logic [3:0]  data_size
);

    logic access;
    logic hit_status, hit_bplo, hit_bphi, hit_ds, hit_rx;
    logic reserved;
    logic err;
    logic wr_ok, rd_ok;
    logic push, pop, full, empty, ready;
    logic overrun, framing;
    logic ovr_set, frm_set, st_clr;
    logic [7:0] head;
    logic [DATA_W-1:0] rd;

    assign access     = apb.psel & apb.penable;
    assign hit_status = (apb.paddr == ADDR_W'(A_STATUS));
    assign hit_bplo   = (apb.paddr == ADDR_W'(A_BP_LO));
    assign hit_bphi   = (apb.paddr == ADDR_W'(A_BP_HI));
    assign hit_ds     = (apb.paddr == ADDR_W'(A_DSIZE));
    assign hit_rx     = (apb.paddr == ADDR_W'(A_RXDATA));
    assign reserved   = ~(hit_status | hit_bplo | hit_bphi | hit_ds | hit_rx);

    assign err = access & (reserved
               | (apb.pwrite & (hit_status | hit_rx))
               | (apb.pwrite & hit_ds & ~ds_legal(32'(apb.pwdata))));

    assign wr_ok = access & apb.pwrite & ~err & ~reset;
    assign rd_ok = access & ~apb.pwrite & ~err & ~reset;

    // Popping frees a slot on the same edge, so a coinciding byte fits.
    assign pop     = rd_ok & hit_rx & ~empty;
    assign push    = rx_valid & ~rx_framing_err & (~full | pop);
    assign ovr_set = rx_valid & ~rx_framing_err & full & ~pop;
    assign frm_set = rx_valid & rx_framing_err;
    assign st_clr  = rd_ok & hit_status;

`ifdef APB_UART_RX_FIFO_EN
    logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count;

    rx_fifo #(
        .DEPTH(FIFO_DEPTH),
        .W    (8)
    ) u_rx_fifo (
        .clk  (clk),
        .reset(reset),
        .push (push),
        .pop  (pop),
        .din  (rx_byte),
        .dout (head),
        .full (full),
        .empty(empty),
        .count(fifo_count)
    );

    assign ready = (fifo_count != '0);
`else
    logic       hold_valid;
    logic [7:0] hold_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_valid <= 1'b0;
        end else if (push) begin
            hold_valid <= 1'b1;
            hold_data  <= rx_byte;
        end else if (pop) begin
            hold_valid <= 1'b0;
        end
    end

    assign full  = hold_valid;
    assign empty = ~hold_valid;
    assign ready = hold_valid;
    assign head  = hold_valid ? hold_data : 8'h00;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_period <= BP_RST;
            data_size  <= DS_RST;
        end else if (wr_ok) begin
            if (hit_bplo) bit_period[7:0]  <= apb.pwdata[7:0];
            if (hit_bphi) bit_period[13:8] <= apb.pwdata[5:0];
            if (hit_ds)   data_size        <= apb.pwdata[3:0];
        end
    end

    // A new error event on the clearing edge survives the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun <= 1'b0;
            framing <= 1'b0;
        end else begin
            overrun <= ovr_set | (overrun & ~st_clr);
            framing <= frm_set | (framing & ~st_clr);
        end
    end

    always_comb begin
        rd = '0;
        if (!reset && apb.psel && !err) begin
            unique case (1'b1)
                hit_status: begin
                    rd[ST_READY]   = ready;
                    rd[ST_OVERRUN] = overrun;
                    rd[ST_FRAMING] = framing;
                end
                hit_bplo: rd[7:0] = bit_period[7:0];
                hit_bphi: rd[5:0] = bit_period[13:8];
                hit_ds:   rd[3:0] = data_size;
                hit_rx:   rd[7:0] = head;
                default:  rd = '0;
            endcase
        end
    end

    assign apb.prdata  = rd;
    assign apb.psaterr = err & ~reset;

endmodule

// File: doc/apb_uart_rx_regs.md
APB_UART_RX_REGS -- requirements
Module: apb_uart_rx_regs

Interface
REQ-001 SHALL have parameter ADDR_W, default 3, APB address width.
REQ-002 SHALL have parameter DATA_W, default 8, APB data width.
REQ-003 SHALL have one clock and a synchronous, active-high reset, with the following ports:
- clk  in  1  sole clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- psel, penable, pwrite  in  1 each  APB subordinate controls; no PREADY, fixed two-cycle transfer.
- paddr  in  ADDR_W  register address.
- pwdata  in  DATA_W  write data.
- prdata  out  DATA_W  read data.
- psaterr  out  1  transfer error.
- rx_valid  in  1  one-cycle pulse from the UART receiver; rx_byte is valid.
- rx_byte  in  8  received character, right-aligned.
- rx_framing_err  in  1  framing error qualifier for rx_valid.
- bit_period  out  14  cycles per bit, to the receiver.
- data_size  out  4  data bits per character, to the receiver.

Function
REQ-004 SHALL define the ACCESS phase as psel & penable; the SETUP phase is psel & !penable.
REQ-005 SHALL use this register map:
- 0 STATUS: RO, {5'b0, framing, overrun, data_ready}.
- 1 reserved.
- 2 BP_LO: RW, bit_period[7:0].
- 3 BP_HI: RW, bit_period[13:8] in bits [5:0]; bits [7:6] read 0.
- 4 DATA_SIZE: RW, bits [3:0].
- 5 reserved.
- 6 RX_DATA: RO, pops on read.
- 7 reserved.
REQ-006 SHALL drive prdata combinationally from paddr whenever psel=1, and drive 0 when psel=0 or on error.
REQ-007 SHALL assert psaterr combinationally during the ACCESS phase only, for any of:
- an access to address 1, 5 or 7;
- a write to address 0 or 6;
- a write to DATA_SIZE with a value other than 5, 7 or 8.
REQ-008 SHALL commit a write at the clk edge ending the ACCESS phase; an erroring write SHALL change no state.
REQ-009 SHALL, on an RX_DATA read, return the oldest byte and pop it at the edge ending the ACCESS phase.
REQ-010 SHALL, on an RX_DATA read while empty, return 0x00 with psaterr=0 and no state change.
REQ-011 SHALL store an rx_valid with rx_framing_err=0 into receive storage when space exists, visible to a read one cycle later.
REQ-012 SHALL, on rx_valid while storage is full with no simultaneous pop, drop the byte and set the overrun bit.
REQ-013 SHALL, on rx_valid coinciding with a pop while full, accept the byte with no overrun.
REQ-014 SHALL, on rx_valid with rx_framing_err=1, discard the byte and set the framing bit.
REQ-015 SHALL keep overrun and framing sticky, clearing both at the edge ending a STATUS read; a set coinciding with the clear SHALL win.
REQ-016 SHALL drive data_ready as 1 exactly when storage is non-empty.

Reset
REQ-017 SHALL, on reset, set bit_period=14'd10, data_size=4'd8, storage empty and overrun=framing=0.
REQ-018 SHALL hold prdata=0 and psaterr=0 while reset is asserted.
REQ-019 SHALL let reset win over any simultaneous transfer or rx_valid; a transfer interrupted by reset is abandoned.

Configuration
REQ-020 SHALL, with APB_UART_RX_FIFO_EN defined, use a 4-entry FIFO as receive storage, with full at 4 entries and wrap-around pointers.
REQ-021 SHALL, without APB_UART_RX_FIFO_EN, use a single holding register, with full at 1 entry.

Structure
REQ-022 SHALL place the register address constants, the STATUS bit indices and the reset values in package apb_uart_pkg.
REQ-023 SHALL implement the FIFO as sub-module rx_fifo (push, pop, full, empty, count).

Verification
REQ-024 SHALL cover the following directed scenarios:
- Reset, then read BP_LO, BP_HI and DATA_SIZE -> 0x0A, 0x00, 0x08; psaterr=0.
- Write DATA_SIZE=0x06 -> psaterr=1 during ACCESS; readback 0x08.
- rx_valid with byte 0xA5 -> STATUS=0x01; read RX_DATA -> 0xA5; then STATUS=0x00.
- rx_valid 0x11, 0x22 (no FIFO) -> STATUS=0x03, RX_DATA=0x11; with FIFO_EN, 5 bytes -> first 4 read back in order, overrun set.
- rx_valid with rx_framing_err=1 -> STATUS=0x04; second STATUS read -> 0x00.
- Read address 5 -> psaterr=1, prdata=0x00; write address 0 -> psaterr=1.
